// File: rtl/cs_seq_pkg.sv
// cs_seq_pkg: shared types and defaults for the cs sequence generator.
//   state_e   - sequencer FSM states
//   mode_e    - cs output encoding (binary / Gray)
//   DEF_*     - default register forced codes
//   bin2gray  - binary to reflected Gray conversion (up to 32 bits)
package cs_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic {
    MODE_BIN  = 1'b0,
    MODE_GRAY = 1'b1
  } mode_e;

  localparam logic [3:0] DEF_RESET_CODE = 4'b1101;
  localparam logic [3:0] DEF_SET_CODE   = 4'b0110;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/cs_fb_checker.sv
// cs_fb_checker: compares the state register's ns feedback against the cs
// value issued one cycle earlier and raises a sticky error on mismatch.
//   clk, reset_n - clock, asynchronous active-low reset
//   ns           - register output observed this cycle
//   prev_cs      - cs issued in the previous cycle
//   prev_valid   - cs_valid in the previous cycle
//   ff_reset/set - register forcing controls this cycle
//   err_clr      - clears err (a simultaneous mismatch keeps it set)
//   err          - sticky mismatch flag
module cs_fb_checker #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] ns,
  input  logic [WIDTH-1:0] prev_cs,
  input  logic             prev_valid,
  input  logic             ff_reset,
  input  logic             ff_set,
  input  logic             err_clr,
  output logic             err
);

  logic prev_forced_reg;
  logic err_reg;
  logic mismatch;

  // A forced code in either the issuing cycle or the observing cycle makes
  // the register's output unrelated to cs, so that pair is skipped.
  assign mismatch = prev_valid && !prev_forced_reg && !ff_reset && !ff_set
                    && (ns != prev_cs);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_forced_reg <= 1'b0;
      err_reg         <= 1'b0;
    end else begin
      prev_forced_reg <= ff_reset | ff_set;
      err_reg         <= mismatch | (err_reg & ~err_clr);
    end
  end

  assign err = err_reg;

endmodule

// File: rtl/cs_seq_gen.sv
// cs_seq_gen: produces the cs bus for a 4-bit async set/reset state register.
// Binary/Gray counter with start/pause/stop/load control, limit detection,
// roll-over detection, resync to the register's forced codes, and feedback
// checking of the register's ns output.
//   inputs : clk, reset_n, start, pause, stop, dir, mode, load, load_val,
//            limit, ff_reset, ff_set, ns, err_clr
//   outputs: cs, cs_valid, busy, done, wrap, err (all registered)
module cs_seq_gen
  import cs_seq_pkg::*;
#(
  parameter int               WIDTH      = 4,
  parameter int               STEP       = 1,
  parameter logic [WIDTH-1:0] RESET_CODE = WIDTH'(DEF_RESET_CODE),
  parameter logic [WIDTH-1:0] SET_CODE   = WIDTH'(DEF_SET_CODE)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             pause,
  input  logic             stop,
  input  logic             dir,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic             ff_reset,
  input  logic             ff_set,
  input  logic [WIDTH-1:0] ns,
  input  logic             err_clr,
  output logic [WIDTH-1:0] cs,
  output logic             cs_valid,
  output logic             busy,
  output logic             done,
  output logic             wrap,
  output logic             err
);

  state_e           state_reg, state_next;
  logic [WIDTH-1:0] cnt_reg, cnt_next;
  logic             valid_next;
  logic             hit, roll;
  logic [WIDTH:0]   up_sum, dn_diff;
  logic [WIDTH-1:0] step_val;

  logic [WIDTH-1:0] cs_next;
  logic             busy_next;

  logic [WIDTH-1:0] cs_reg, prev_cs_reg;
  logic             cs_valid_reg, prev_valid_reg;
  logic             busy_reg, done_reg, wrap_reg;

  // One extra bit catches carry (up) or borrow (down) for wrap detection.
  assign up_sum  = {1'b0, cnt_reg} + (WIDTH+1)'(STEP);
  assign dn_diff = {1'b0, cnt_reg} - (WIDTH+1)'(STEP);

  // State / counter register, plus the output stage that registers the
  // next-cycle view so outputs line up with the count they describe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      cs_reg         <= '0;
      cs_valid_reg   <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      wrap_reg       <= 1'b0;
      prev_cs_reg    <= '0;
      prev_valid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      cs_reg         <= cs_next;
      cs_valid_reg   <= valid_next;
      busy_reg       <= busy_next;
      done_reg       <= hit;
      wrap_reg       <= roll;
      prev_cs_reg    <= cs_reg;
      prev_valid_reg <= cs_valid_reg;
    end
  end

  // Next-state and counter logic. Priority:
  // ff_reset > ff_set > stop > load > pause > start.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    valid_next = cs_valid_reg;
    hit        = 1'b0;
    roll       = 1'b0;
    step_val   = dir ? up_sum[WIDTH-1:0] : dn_diff[WIDTH-1:0];
    if (ff_reset) begin
      cnt_next   = RESET_CODE;
      state_next = IDLE;
      valid_next = 1'b0;
    end else if (ff_set) begin
      cnt_next   = SET_CODE;
      state_next = IDLE;
      valid_next = 1'b0;
    end else if (stop) begin
      state_next = IDLE;
      valid_next = 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (load) begin
            cnt_next = load_val;
          end else if (start) begin
            state_next = RUN;
            valid_next = 1'b1;
          end
        end
        RUN: begin
          if (load) begin
            // load is not honoured while stepping; fall through to pause/step
            cnt_next = cnt_reg;
          end
          if (pause) begin
            state_next = PAUSE;
          end else begin
            cnt_next = step_val;
            roll     = dir ? up_sum[WIDTH] : dn_diff[WIDTH];
            if (step_val == limit) begin
              hit        = 1'b1;
              state_next = DONE;
            end
          end
        end
        PAUSE: begin
          if (load) begin
            cnt_next = load_val;
          end else if (!pause && start) begin
            state_next = RUN;
            valid_next = 1'b1;
          end
        end
        DONE: begin
          state_next = start ? RUN : IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Output decode of the next-cycle values.
  always_comb begin
    cs_next   = (mode == MODE_GRAY) ? WIDTH'(bin2gray(32'(cnt_next))) : cnt_next;
    busy_next = (state_next == RUN) || (state_next == PAUSE);
  end

  cs_fb_checker #(
    .WIDTH (WIDTH)
  ) u_fb_checker (
    .clk        (clk),
    .reset_n    (reset_n),
    .ns         (ns),
    .prev_cs    (prev_cs_reg),
    .prev_valid (prev_valid_reg),
    .ff_reset   (ff_reset),
    .ff_set     (ff_set),
    .err_clr    (err_clr),
    .err        (err)
  );

  assign cs       = cs_reg;
  assign cs_valid = cs_valid_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign wrap     = wrap_reg;

endmodule

// File: tb/tb_cs_seq_gen.sv
// tb_cs_seq_gen: directed bench for cs_seq_gen. Each step drives inputs,
// pushes the expected post-edge outputs to a scoreboard queue, then pops and
// compares after the clock edge. ns normally loops back cs from the previous
// cycle, mimicking the downstream register; it can be forced for error tests.
module tb_cs_seq_gen;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0, pause = 1'b0, stop = 1'b0;
  logic       dir = 1'b1, mode = 1'b0, load = 1'b0;
  logic [3:0] load_val = 4'h0, limit = 4'h0;
  logic       ff_reset = 1'b0, ff_set = 1'b0, err_clr = 1'b0;
  logic [3:0] ns = 4'h0;
  logic [3:0] cs;
  logic       cs_valid, busy, done, wrap, err;

  always #5 clk = ~clk;

  cs_seq_gen dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .pause    (pause),
    .stop     (stop),
    .dir      (dir),
    .mode     (mode),
    .load     (load),
    .load_val (load_val),
    .limit    (limit),
    .ff_reset (ff_reset),
    .ff_set   (ff_set),
    .ns       (ns),
    .err_clr  (err_clr),
    .cs       (cs),
    .cs_valid (cs_valid),
    .busy     (busy),
    .done     (done),
    .wrap     (wrap),
    .err      (err)
  );

  // flags field order: cs_valid, busy, done, wrap, err
  typedef struct packed {
    logic [3:0] cs;
    logic [4:0] flags;
  } obs_t;

  obs_t       exp_q[$];
  int         total = 0;
  int         bad = 0;
  logic       loop = 1'b1;
  logic [3:0] ns_val = 4'h0;
  logic [3:0] last_cs = 4'h0;
  logic [3:0] gprev;

  task automatic check(input string tag);
    obs_t e, o;
    o = {cs, cs_valid, busy, done, wrap, err};
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL %s: scoreboard empty, observed cs=%h flags=%b", tag, o.cs, o.flags);
    end else begin
      e = exp_q.pop_front();
      assert (o === e) else begin
        bad++;
        $error("FAIL %s: observed cs=%h v/b/d/w/e=%b required cs=%h v/b/d/w/e=%b",
               tag, o.cs, o.flags, e.cs, e.flags);
      end
    end
    $display("step %-14s cs=%h v=%b busy=%b done=%b wrap=%b err=%b",
             tag, cs, cs_valid, busy, done, wrap, err);
  endtask

  task automatic step(input string tag, input logic [3:0] e_cs, input logic [4:0] e_fl);
    ns      = loop ? last_cs : ns_val;
    last_cs = cs;
    exp_q.push_back({e_cs, e_fl});
    @(posedge clk);
    #1;
    start = 1'b0; stop = 1'b0; load = 1'b0;
    ff_reset = 1'b0; ff_set = 1'b0; err_clr = 1'b0;
    check(tag);
  endtask

  task automatic onebit(input string tag);
    total++;
    assert ($countones(cs ^ gprev) == 1) else begin
      bad++;
      $error("FAIL %s: observed %h after %h, required exactly one bit change", tag, cs, gprev);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back('0);
    check("reset");
    reset_n = 1'b1;

    // binary up count to limit 5
    dir = 1'b1; mode = 1'b0; limit = 4'd5;
    start = 1'b1; step("t1_start", 4'h0, 5'b11000);
    step("t1_c1", 4'h1, 5'b11000);
    step("t1_c2", 4'h2, 5'b11000);
    step("t1_c3", 4'h3, 5'b11000);
    step("t1_c4", 4'h4, 5'b11000);
    step("t1_done", 4'h5, 5'b10100);
    step("t1_idle", 4'h5, 5'b10000);

    // load E, wrap through zero, done at 2
    load_val = 4'hE; load = 1'b1; step("t2_load", 4'hE, 5'b10000);
    limit = 4'd2;
    start = 1'b1; step("t2_start", 4'hE, 5'b11000);
    step("t2_f", 4'hF, 5'b11000);
    step("t2_wrap", 4'h0, 5'b11010);
    step("t2_1", 4'h1, 5'b11000);
    step("t2_done", 4'h2, 5'b10100);
    step("t2_idle", 4'h2, 5'b10000);

    // Gray count from 0, load ignored in RUN
    mode = 1'b1; limit = 4'hF;
    load_val = 4'h0; load = 1'b1; step("t3_load", 4'h0, 5'b10000);
    start = 1'b1; step("t3_start", 4'h0, 5'b11000);
    gprev = cs; step("t3_g1", 4'b0001, 5'b11000); onebit("t3_1bit_a");
    gprev = cs; load_val = 4'h9; load = 1'b1;
    step("t3_g2_noload", 4'b0011, 5'b11000); onebit("t3_1bit_b");
    gprev = cs; step("t3_g3", 4'b0010, 5'b11000); onebit("t3_1bit_c");
    gprev = cs; step("t3_g4", 4'b0110, 5'b11000); onebit("t3_1bit_d");

    // pause 3 cycles, hold without start, resume, stop, forced set code
    pause = 1'b1;
    step("t4_pause1", 4'b0110, 5'b11000);
    step("t4_pause2", 4'b0110, 5'b11000);
    step("t4_pause3", 4'b0110, 5'b11000);
    pause = 1'b0; step("t4_hold", 4'b0110, 5'b11000);
    start = 1'b1; step("t4_resume", 4'b0110, 5'b11000);
    step("t4_g5", 4'b0111, 5'b11000);
    mode = 1'b0; step("t4_bin6", 4'h6, 5'b11000);
    stop = 1'b1; step("t4_stop", 4'h6, 5'b00000);
    start = 1'b1; step("t4_restart", 4'h6, 5'b11000);
    step("t4_7", 4'h7, 5'b11000);
    ff_set = 1'b1; step("t4_ffset", 4'h6, 5'b00000);

    // feedback error detection and clearing
    start = 1'b1; step("t5_start", 4'h6, 5'b11000);
    loop = 1'b0; ns_val = 4'h0; step("t5_noprev", 4'h7, 5'b11000);
    step("t5_mismatch", 4'h8, 5'b11001);
    loop = 1'b1; step("t5_sticky", 4'h9, 5'b11001);
    err_clr = 1'b1; step("t5_clr", 4'hA, 5'b11000);
    loop = 1'b0; err_clr = 1'b1; step("t5_clr_vs_mis", 4'hB, 5'b11001);
    loop = 1'b1; err_clr = 1'b1; step("t5_clr2", 4'hC, 5'b11000);

    // done and wrap on the same step
    limit = 4'h0;
    step("t5_d", 4'hD, 5'b11000);
    step("t5_e", 4'hE, 5'b11000);
    step("t5_f", 4'hF, 5'b11000);
    step("t5_done_wrap", 4'h0, 5'b10110);
    step("t5_idle", 4'h0, 5'b10000);

    // down count with wrap, done at E
    dir = 1'b0; limit = 4'hE;
    start = 1'b1; step("t6_start", 4'h0, 5'b11000);
    step("t6_dn_wrap", 4'hF, 5'b11010);
    step("t6_dn_done", 4'hE, 5'b10100);
    step("t6_idle", 4'hE, 5'b10000);

    // ff_reset outranks ff_set
    start = 1'b1; step("t6_run", 4'hE, 5'b11000);
    ff_reset = 1'b1; ff_set = 1'b1; step("t6_ffreset", 4'hD, 5'b00000);

    // asynchronous reset mid-run with err set
    start = 1'b1; step("t7_start", 4'hD, 5'b11000);
    step("t7_c", 4'hC, 5'b11000);
    loop = 1'b0; ns_val = 4'h0; step("t7_err", 4'hB, 5'b11001);
    #2 reset_n = 1'b0;
    #1;
    exp_q.push_back('0);
    check("t7_async_rst");
    #2 reset_n = 1'b1;
    loop = 1'b1; step("t7_after", 4'h0, 5'b00000);
    start = 1'b1; step("t7_restart", 4'h0, 5'b11000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
